// File: rtl/drone_rx_line_deframer.sv
// Receive-side line deframer: hunts for AA 55 sync in the radio byte stream,
// latches the line number, forwards payload bytes to the frame buffer and
// checks the trailing XOR checksum.
//
// state  | meaning
// -------+---------------------------------------------------------------
// HUNT   | idle, waiting for the first sync byte 0xAA
// SYNC1  | 0xAA seen, expecting 0x55 (a repeated 0xAA keeps the hunt alive)
// LINE_H | expecting the line number high byte
// LINE_L | expecting the line number low byte
// DATA   | receiving payload bytes, one frame-buffer write per byte
// CHECK  | expecting the checksum byte, reports line result
module drone_rx_line_deframer #(
    parameter int PAYLOAD   = 64,
    parameter int MAX_LINES = 480,
    parameter int ADDR_W    = 15,
    parameter int TIMEOUT   = 1024
) (
    input  logic              sys_clock,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              line_done,
    output logic              line_ok,
    output logic [15:0]       line_num,
    output logic              frame_start,
    output logic [15:0]       err_cnt
);

    localparam int IDX_W = $clog2(PAYLOAD);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        HUNT,
        SYNC1,
        LINE_H,
        LINE_L,
        DATA,
        CHECK
    } state_t;

    state_t            state_q;
    logic [7:0]        line_h_q;
    logic [7:0]        csum_q;
    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] base_q;
    logic              in_range_q;
    logic [TMO_W-1:0]  tmo_q;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              line_done_q;
    logic              line_ok_q;
    logic [15:0]       line_num_q;
    logic              frame_start_q;
    logic [15:0]       err_cnt_q;

    logic [15:0]       line_d;
    logic [31:0]       base_full_d;
    logic [ADDR_W-1:0] base_d;
    logic              in_range_d;
    logic              csum_ok_d;
    logic [15:0]       err_cnt_d;

    // Line base address, range check, checksum compare and saturated error increment.
    always_comb begin
        line_d      = {line_h_q, rx_data};
        base_full_d = 32'(line_d) * 32'(PAYLOAD);
        base_d      = base_full_d[ADDR_W-1:0];
        in_range_d  = 32'(line_d) < 32'(MAX_LINES);
        csum_ok_d   = in_range_q && (rx_data == csum_q);
        err_cnt_d   = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
    end

    // Packet FSM with idle timeout; all outputs registered.
    always_ff @(posedge sys_clock or negedge rstn) begin
        if (!rstn) begin
            state_q       <= HUNT;
            line_h_q      <= '0;
            csum_q        <= '0;
            idx_q         <= '0;
            base_q        <= '0;
            in_range_q    <= 1'b0;
            tmo_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            line_done_q   <= 1'b0;
            line_ok_q     <= 1'b0;
            line_num_q    <= '0;
            frame_start_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            wr_en_q       <= 1'b0;
            line_done_q   <= 1'b0;
            line_ok_q     <= 1'b0;
            frame_start_q <= 1'b0;
            if (state_q != HUNT && !rx_valid) begin
                // Abandon the packet silently (no line_done) after TIMEOUT idle cycles.
                if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_q   <= HUNT;
                    tmo_q     <= '0;
                    err_cnt_q <= err_cnt_d;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else if (rx_valid) begin
                tmo_q <= '0;
                case (state_q)
                    HUNT: begin
                        if (rx_data == 8'hAA) state_q <= SYNC1;
                    end
                    SYNC1: begin
                        if (rx_data == 8'h55)      state_q <= LINE_H;
                        else if (rx_data != 8'hAA) state_q <= HUNT;
                    end
                    LINE_H: begin
                        line_h_q <= rx_data;
                        csum_q   <= rx_data;
                        state_q  <= LINE_L;
                    end
                    LINE_L: begin
                        line_num_q <= line_d;
                        base_q     <= base_d;
                        in_range_q <= in_range_d;
                        csum_q     <= csum_q ^ rx_data;
                        idx_q      <= '0;
                        state_q    <= DATA;
                    end
                    DATA: begin
                        // Writes go out before the checksum is known; only out-of-range lines are suppressed.
                        wr_en_q   <= in_range_q;
                        wr_addr_q <= base_q + ADDR_W'(idx_q);
                        wr_data_q <= rx_data;
                        csum_q    <= csum_q ^ rx_data;
                        idx_q     <= idx_q + 1'b1;
                        if (idx_q == IDX_W'(PAYLOAD - 1)) state_q <= CHECK;
                    end
                    CHECK: begin
                        line_done_q   <= 1'b1;
                        line_ok_q     <= csum_ok_d;
                        frame_start_q <= csum_ok_d && (line_num_q == 16'd0);
                        if (!csum_ok_d) err_cnt_q <= err_cnt_d;
                        state_q <= HUNT;
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign line_done   = line_done_q;
    assign line_ok     = line_ok_q;
    assign line_num    = line_num_q;
    assign frame_start = frame_start_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_drone_rx_line_deframer.sv
// Scoreboard bench for the line deframer: expected writes and line results are
// queued as bytes are driven and matched (value and cycle) when the DUT emits them.
module tb_drone_rx_line_deframer;

    localparam int PAYLOAD   = 4;
    localparam int MAX_LINES = 480;
    localparam int ADDR_W    = 15;
    localparam int TIMEOUT   = 16;

    logic              sys_clock = 1'b0;
    logic              rstn      = 1'b1;
    logic              rx_valid  = 1'b0;
    logic [7:0]        rx_data   = 8'h00;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              line_done;
    logic              line_ok;
    logic [15:0]       line_num;
    logic              frame_start;
    logic [15:0]       err_cnt;

    drone_rx_line_deframer #(
        .PAYLOAD   (PAYLOAD),
        .MAX_LINES (MAX_LINES),
        .ADDR_W    (ADDR_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .sys_clock   (sys_clock),
        .rstn        (rstn),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .line_done   (line_done),
        .line_ok     (line_ok),
        .line_num    (line_num),
        .frame_start (frame_start),
        .err_cnt     (err_cnt)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct {
        int ok;
        int line;
        int fs;
        int err;
        int cyc;
    } ln_t;

    wr_t wr_q[$];
    ln_t ln_q[$];
    wr_t mw;
    ln_t ml;

    int n_chk   = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_err = 0;

    always @(posedge sys_clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: every write and every line result must match the head of its queue.
    always @(negedge sys_clock) begin
        if (rstn) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_wr", 1, 0);
                end else begin
                    mw = wr_q.pop_front();
                    check("wr_addr", 32'(wr_addr), mw.addr);
                    check("wr_data", 32'(wr_data), mw.data);
                    check("wr_cycle", cyc, mw.cyc);
                end
            end
            if (line_done) begin
                if (ln_q.size() == 0) begin
                    check("unexpected_line_done", 1, 0);
                end else begin
                    ml = ln_q.pop_front();
                    check("line_ok", 32'(line_ok), ml.ok);
                    check("line_num", 32'(line_num), ml.line);
                    check("frame_start", 32'(frame_start), ml.fs);
                    check("err_cnt_at_done", 32'(err_cnt), ml.err);
                    check("line_cycle", cyc, ml.cyc);
                end
            end else if (frame_start) begin
                check("stray_frame_start", 1, 0);
            end
        end
    end

    task automatic drive(input logic [7:0] b);
        @(negedge sys_clock);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sys_clock);
            rx_valid = 1'b0;
        end
    endtask

    task automatic push_wr(input int addr, input int data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        w.cyc  = cyc + 1;
        wr_q.push_back(w);
    endtask

    // Full packet; csum_xor corrupts the checksum, a stall of stall_len idle cycles follows payload byte stall_at.
    task automatic send_pkt(input int line, input logic [7:0] pl [PAYLOAD],
                            input logic [7:0] csum_xor, input int stall_at, input int stall_len);
        logic [7:0] cs;
        logic [7:0] lh;
        logic [7:0] ll;
        bit         inr;
        bit         ok;
        ln_t        l;
        lh  = 8'((line >> 8) & 255);
        ll  = 8'(line & 255);
        inr = (line < MAX_LINES);
        cs  = lh ^ ll;
        drive(8'hAA);
        drive(8'h55);
        drive(lh);
        drive(ll);
        for (int i = 0; i < PAYLOAD; i++) begin
            drive(pl[i]);
            if (inr) push_wr(line * PAYLOAD + i, int'(pl[i]));
            cs = cs ^ pl[i];
            if (i == stall_at) idle(stall_len);
        end
        ok = inr && (csum_xor == 8'h00);
        if (!ok) exp_err++;
        drive(cs ^ csum_xor);
        l.ok   = int'(ok);
        l.line = line;
        l.fs   = int'(ok && line == 0);
        l.err  = exp_err;
        l.cyc  = cyc + 1;
        ln_q.push_back(l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rstn = 1'b0;
        #1;
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_line_done", 32'(line_done), 0);
        check("rst_line_num", 32'(line_num), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        @(negedge sys_clock);
        rstn = 1'b1;
        idle(3);

        // 1: basic line 5
        send_pkt(5, '{8'h11, 8'h22, 8'h33, 8'h44}, 8'h00, -1, 0);
        // 2: line 0 back-to-back, pulses one cycle after CSUM
        send_pkt(0, '{8'h01, 8'h02, 8'h03, 8'h04}, 8'h00, -1, 0);
        @(negedge sys_clock);
        rx_valid = 1'b0;
        check("s2_line_done_latency", 32'(line_done), 1);
        check("s2_frame_start_latency", 32'(frame_start), 1);
        idle(2);
        // sync bytes inside payload are plain data
        send_pkt(7, '{8'hAA, 8'h55, 8'hAA, 8'h55}, 8'h00, -1, 0);
        idle(2);
        // 3: bad checksum
        send_pkt(5, '{8'h11, 8'h22, 8'h33, 8'h44}, 8'h03, -1, 0);
        idle(2);
        // 4: out-of-range line, valid checksum
        send_pkt(480, '{8'h10, 8'h20, 8'h30, 8'h40}, 8'h00, -1, 0);
        idle(2);
        // last valid line, highest address
        send_pkt(479, '{8'hDE, 8'hAD, 8'hBE, 8'hEF}, 8'h00, -1, 0);
        // stall one short of the timeout must not abandon the packet
        send_pkt(3, '{8'h5A, 8'hA5, 8'h0F, 8'hF0}, 8'h00, 1, TIMEOUT - 1);
        idle(2);
        check("no_err_after_short_stall", 32'(err_cnt), exp_err);

        // 5: garbage, resync through AA AA 55, then timeout mid-DATA
        drive(8'h12);
        drive(8'hAA);
        drive(8'hAA);
        drive(8'h55);
        drive(8'h00);
        drive(8'h01);
        drive(8'h77); push_wr(4, 8'h77);
        drive(8'h88); push_wr(5, 8'h88);
        idle(TIMEOUT + 4);
        exp_err++;
        check("s5_timeout_err_cnt", 32'(err_cnt), exp_err);
        check("s5_line_num", 32'(line_num), 1);
        send_pkt(2, '{8'h99, 8'h00, 8'hFF, 8'h42}, 8'h00, -1, 0);
        idle(2);

        // 6: reset mid-DATA
        drive(8'hAA);
        drive(8'h55);
        drive(8'h00);
        drive(8'h07);
        drive(8'h11); push_wr(28, 8'h11);
        drive(8'h22);
        @(posedge sys_clock);
        #1;
        rstn     = 1'b0;
        rx_valid = 1'b0;
        #1;
        check("s6_wr_en", 32'(wr_en), 0);
        check("s6_wr_addr", 32'(wr_addr), 0);
        check("s6_wr_data", 32'(wr_data), 0);
        check("s6_line_done", 32'(line_done), 0);
        check("s6_line_ok", 32'(line_ok), 0);
        check("s6_line_num", 32'(line_num), 0);
        check("s6_frame_start", 32'(frame_start), 0);
        check("s6_err_cnt", 32'(err_cnt), 0);
        exp_err = 0;
        @(negedge sys_clock);
        rstn = 1'b1;
        idle(2);
        send_pkt(9, '{8'h01, 8'h23, 8'h45, 8'h67}, 8'h00, -1, 0);
        idle(4);

        check("wr_queue_drained", wr_q.size(), 0);
        check("line_queue_drained", ln_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/drone_rx_line_deframer.md
Name: drone_rx_line_deframer

Overview:
- Sits directly downstream of the radio receiver inside the receive top, between the receiver's byte stream and the frame-buffer write port.
- Hunts for line packets in the received byte stream and strips header and checksum.
- Writes payload bytes to frame-buffer addresses derived from the packet's line number.
- Reports per-line checksum status, frame start, and a saturating error count.

Parameters:
PAYLOAD, 64, payload bytes per line packet (>=2)
MAX_LINES, 480, lines per frame; line numbers >= MAX_LINES are rejected
ADDR_W, 15, frame-buffer byte address width; must cover MAX_LINES*PAYLOAD
TIMEOUT, 1024, idle cycles mid-packet before abandoning the packet

Ports:
sys_clock  in  1  system clock, all logic rising-edge
rstn  in  1  asynchronous active-low reset
rx_valid  in  1  rx_data is valid this cycle (single-cycle qualifier, no backpressure)
rx_data  in  8  received byte
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  frame-buffer byte address
wr_data  out  8  frame-buffer write data
line_done  out  1  one-cycle pulse at the end of each complete packet
line_ok  out  1  checksum result, valid while line_done=1
line_num  out  16  line number of the current or last packet
frame_start  out  1  one-cycle pulse coincident with line_done when line_num=0 and line_ok=1
err_cnt  out  16  saturating count of bad checksums, rejected lines and timeouts

Behaviour:
- Reset: all outputs 0, state HUNT, checksum 0, timeout counter 0.
- Packet format: 0xAA, 0x55, LINE[15:8], LINE[7:0], PAYLOAD data bytes, CSUM.
- CSUM = XOR of LINE bytes and all payload bytes.
- Only cycles with rx_valid=1 advance the FSM.
- States and transitions:
  - HUNT: on 0xAA go to SYNC1.
  - SYNC1: 0x55 goes to LINE_H; 0xAA stays in SYNC1; any other byte goes to HUNT.
  - LINE_H: latch high byte, go to LINE_L.
  - LINE_L: latch low byte, go to DATA. Byte index is set to 0.
  - DATA: on each accepted byte, increment the index. After byte PAYLOAD-1, go to CHECK.
  - CHECK: compare the received byte with the running XOR. Pulse line_done with line_ok, then go to HUNT.
- Writes:
  - Each DATA byte produces wr_en=1 exactly one cycle after it is accepted.
  - wr_addr = line*PAYLOAD + index; wr_data = the byte.
  - Writes are issued before the checksum is known; bad lines are signalled only via line_ok=0.
- Line range check: if LINE >= MAX_LINES, the packet is still parsed to CHECK but no wr_en is issued. line_done pulses with line_ok=0 and err_cnt increments.
- Latency: line_done, line_ok and frame_start are asserted one cycle after the CSUM byte is accepted.
- line_num updates to the latched LINE in the cycle after LINE_L is accepted, and holds until the next packet.
- Timeout:
  - In any state other than HUNT, the counter counts cycles with rx_valid=0 and clears on rx_valid=1.
  - Reaching TIMEOUT returns the FSM to HUNT, increments err_cnt, and produces no line_done.
- Sync bytes inside payload are treated as data; no resync occurs mid-packet.
- err_cnt: increments on a bad checksum, a range reject, or a timeout. At most one error is counted per packet. It saturates at 0xFFFF.
- Reset asserted mid-packet: immediate return to HUNT with all outputs 0. No partial line_done is produced.
- rx_valid continuously high (one byte per cycle) must be sustained with no dropped bytes.

Test Plan:
(All scenarios use PAYLOAD=4, MAX_LINES=480, TIMEOUT=16.)
1. Send AA 55 00 05 11 22 33 44 CSUM=0x05^0x11^0x22^0x33^0x44=0x41.
   - Four writes at addresses 20..23 with data 11,22,33,44.
   - line_done=1, line_ok=1, line_num=5, frame_start=0, err_cnt=0.
2. Line 0 packet AA 55 00 00 01 02 03 04 04, sent back-to-back with rx_valid held high.
   - Writes at addresses 0..3.
   - frame_start and line_done pulse together one cycle after the CSUM byte.
3. Scenario 1 with CSUM=0x42.
   - The four writes still occur.
   - line_ok=0, frame_start=0, err_cnt=1.
4. Line 0x01E0 (480), valid checksum.
   - No wr_en.
   - line_done with line_ok=0; err_cnt increments by 1.
5. Send garbage 12 AA AA 55 00 01 ..., then stall rx_valid for 16 cycles after the second payload byte.
   - Resync via the AA AA 55 path.
   - Timeout returns the FSM to HUNT with no line_done; err_cnt increments.
   - A following valid packet parses correctly.
6. Assert rstn low mid-DATA.
   - All outputs are 0 within the same cycle.
   - After release, a valid packet parses normally.
